// File: rtl/mem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module  : mem_arbiter_if
// Purpose : Bundles the cpu/loader request ports, clear control and RAM bus.
// Revision: 1.0
//==============================================================================
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;

  logic          clr_start;
  logic          clr_busy;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Environment side: requesters, clear source and the RAM itself.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    output clr_start,
    input  clr_busy,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    input  clr_start,
    output clr_busy,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : mem_arbiter
// Purpose : Round-robin cpu/loader arbiter for a single-port RAM with zero-fill.
// Revision: 1.0
//==============================================================================
module mem_arbiter #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  localparam logic [AW:0] c_clr_last = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_clr_one  = (AW+1)'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio_ldr;
  logic          r_gnt_ldr;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic [AW:0]   r_clr_cnt;
  logic          w_any_req;
  logic          w_pick_ldr;
  logic          w_grant;
  logic          w_done_rd;

  assign w_any_req  = bus.cpu_req | bus.ldr_req;
  // r_prio_ldr set means the loader was not granted last, so it wins a tie.
  assign w_pick_ldr = bus.ldr_req & (~bus.cpu_req | r_prio_ldr);
  assign w_grant    = (r_state == IDLE) & ~bus.clr_start & w_any_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.clr_start)  w_state_nxt = CLEAR;
        else if (w_any_req) w_state_nxt = ACCESS;
      end
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      CLEAR:   if (r_clr_cnt == c_clr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_ldr  <= 1'b0;
      r_gnt_ldr   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_clr_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_ldr  <= w_pick_ldr;
        r_prio_ldr <= ~w_pick_ldr;
        r_we       <= w_pick_ldr ? bus.ldr_we    : bus.cpu_we;
        r_addr     <= w_pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
        r_wdata    <= w_pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
      end
      if (r_state == IDLE)       r_clr_cnt <= '0;
      else if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + c_clr_one;
      if (w_done_rd) begin
        if (r_gnt_ldr) r_ldr_rdata <= bus.mem_rdata;
        else           r_cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  assign w_done_rd = (r_state == DONE) & ~r_we;

  // mem_rdata is the RAM's own output register; forwarding it during DONE
  // aligns read data with ack without any path from the request inputs.
  assign bus.cpu_ack   = (r_state == DONE) & ~r_gnt_ldr;
  assign bus.ldr_ack   = (r_state == DONE) &  r_gnt_ldr;
  assign bus.cpu_rdata = (w_done_rd & ~r_gnt_ldr) ? bus.mem_rdata : r_cpu_rdata;
  assign bus.ldr_rdata = (w_done_rd &  r_gnt_ldr) ? bus.mem_rdata : r_ldr_rdata;
  assign bus.clr_busy  = (r_state == CLEAR);

  assign bus.mem_en    = (r_state == ACCESS) | (r_state == CLEAR);
  assign bus.mem_we    = ((r_state == ACCESS) & r_we) | (r_state == CLEAR);
  assign bus.mem_addr  = (r_state == CLEAR) ? r_clr_cnt[AW-1:0] : r_addr;
  assign bus.mem_wdata = (r_state == CLEAR) ? '0 : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter against a behavioural RAM model.
// Revision: 1.0
//==============================================================================
module tb_mem_arbiter;

  logic clock;
  logic reset_n;

  mem_arbiter_if #(.AW(8), .DW(16)) bus ();

  mem_arbiter #(.AW(8), .DW(16), .DEPTH(256)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical single-port synchronous RAM driven by the DUT.
  logic [15:0] ram [256];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int          n_checks;
  int          n_fail;
  logic [15:0] model_mem [256];
  bit          written   [256];
  logic [15:0] exp_cpu_rd;
  logic [15:0] exp_ldr_rd;

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    exp_cpu_rd = 16'h0;
    exp_ldr_rd = 16'h0;
  endtask

  // One complete transaction on one port; lat is -1 if no ack within budget.
  task automatic do_access(input logic is_ldr, input logic we, input logic [7:0] addr,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    rd   = 16'h0;
    @(posedge clock); #1;
    if (is_ldr) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (bus.cpu_ack && bus.ldr_ack) begin
        n_fail++;
        $display("FAIL ack_overlap: cpu_ack=%0b ldr_ack=%0b, required not both 1", bus.cpu_ack, bus.ldr_ack);
      end
      if (is_ldr ? bus.ldr_ack : bus.cpu_ack) begin
        seen = 1'b1;
        lat  = i;
        rd   = is_ldr ? bus.ldr_rdata : bus.cpu_rdata;
      end
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    n_checks++;
    if ({bus.cpu_ack, bus.ldr_ack} !== 2'b00) begin
      n_fail++; $display("FAIL reset_acks: got %b, required 00", {bus.cpu_ack, bus.ldr_ack});
    end
    n_checks++;
    if ({bus.clr_busy, bus.mem_en, bus.mem_we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 000", {bus.clr_busy, bus.mem_en, bus.mem_we});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 24'h0) begin
      n_fail++; $display("FAIL reset_membus: got %h, required 0", {bus.mem_addr, bus.mem_wdata});
    end
    n_checks++;
    if ({bus.cpu_rdata, bus.ldr_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h, required 0", {bus.cpu_rdata, bus.ldr_rdata});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({bus.clr_busy, bus.mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, required 00", {bus.clr_busy, bus.mem_en});
    end
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] rd;
    do_access(1'b0, 1'b1, 8'h05, 16'h1234, lat, rd);
    model_mem[5] = 16'h1234; written[5] = 1'b1;
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL wr_latency: got %0d, required 2", lat); end
    do_access(1'b0, 1'b0, 8'h05, 16'h0, lat, rd);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL rd_latency: got %0d, required 2", lat); end
    n_checks++;
    if (rd !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h, required 1234", rd); end
    exp_cpu_rd = 16'h1234;
  endtask

  task automatic test_random();
    int lat; logic [15:0] rd; logic port; logic we; logic [7:0] a; logic [15:0] d;
    for (int n = 0; n < 24; n++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 255));
      d    = 16'($urandom);
      if (!we && !written[a]) we = 1'b1;
      do_access(port, we, a, d, lat, rd);
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL rand_latency: txn %0d got %0d, required 2", n, lat); end
      if (we) begin
        model_mem[a] = d; written[a] = 1'b1;
      end else begin
        n_checks++;
        if (rd !== model_mem[a]) begin
          n_fail++; $display("FAIL rand_rdata: txn %0d addr %h got %h, required %h", n, a, rd, model_mem[a]);
        end
        if (port) exp_ldr_rd = model_mem[a];
        else      exp_cpu_rd = model_mem[a];
      end
      @(posedge clock); #1;
      n_checks++;
      if (bus.cpu_rdata !== exp_cpu_rd || bus.ldr_rdata !== exp_ldr_rd) begin
        n_fail++;
        $display("FAIL rdata_hold: cpu %h ldr %h, required cpu %h ldr %h",
                 bus.cpu_rdata, bus.ldr_rdata, exp_cpu_rd, exp_ldr_rd);
      end
    end
  endtask

  task automatic test_round_robin();
    int lat; logic [15:0] rd; int ngr;
    int gport [4]; int gcyc [4]; logic [15:0] gdat [4];
    do_access(1'b0, 1'b1, 8'h10, 16'hC0DE, lat, rd); model_mem[8'h10] = 16'hC0DE; written[8'h10] = 1'b1;
    do_access(1'b1, 1'b1, 8'h20, 16'hBEEF, lat, rd); model_mem[8'h20] = 16'hBEEF; written[8'h20] = 1'b1;
    do_reset();
    ngr = 0;
    @(posedge clock); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h20;
    for (int c = 1; c <= 30 && ngr < 4; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (bus.cpu_ack && bus.ldr_ack) begin
        n_fail++; $display("FAIL rr_ack_overlap: both acks high in cycle %0d, required at most one", c);
      end
      if (bus.cpu_ack || bus.ldr_ack) begin
        gport[ngr] = bus.ldr_ack ? 1 : 0;
        gcyc[ngr]  = c;
        gdat[ngr]  = bus.ldr_ack ? bus.ldr_rdata : bus.cpu_rdata;
        ngr++;
      end
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= ngr || gport[k] != (k % 2)) begin
        n_fail++; $display("FAIL rr_order: grant %0d got port %0d, required %0d", k, (k < ngr) ? gport[k] : -1, k % 2);
      end
      n_checks++;
      if (k >= ngr || gcyc[k] != 2 + 3 * k) begin
        n_fail++; $display("FAIL rr_timing: grant %0d got cycle %0d, required %0d", k, (k < ngr) ? gcyc[k] : -1, 2 + 3 * k);
      end
      n_checks++;
      if (k >= ngr || gdat[k] !== ((k % 2) ? model_mem[8'h20] : model_mem[8'h10])) begin
        n_fail++; $display("FAIL rr_rdata: grant %0d got %h", k, (k < ngr) ? gdat[k] : 16'hxxxx);
      end
    end
    exp_cpu_rd = model_mem[8'h10];
    exp_ldr_rd = model_mem[8'h20];
  endtask

  task automatic test_clr_in_access();
    int lat; logic [15:0] rd; bit busy_seen;
    busy_seen = 1'b0;
    @(posedge clock); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h77; bus.cpu_wdata = 16'h5AA5;
    @(posedge clock); #1;
    bus.clr_start = 1'b1;
    n_checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11) begin
      n_fail++; $display("FAIL access_strobes: got %b, required 11", {bus.mem_en, bus.mem_we});
    end
    @(posedge clock); #1;
    bus.clr_start = 1'b0;
    n_checks++;
    if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL clr_in_access_ack: got %b, required 1", bus.cpu_ack); end
    bus.cpu_req = 1'b0;
    model_mem[8'h77] = 16'h5AA5; written[8'h77] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.clr_busy !== 1'b0) busy_seen = 1'b1;
      @(posedge clock); #1;
    end
    n_checks++;
    if (busy_seen) begin n_fail++; $display("FAIL clr_ignored: clr_busy got 1, required 0"); end
    do_access(1'b0, 1'b0, 8'h77, 16'h0, lat, rd);
    exp_cpu_rd = model_mem[8'h77];
    n_checks++;
    if (rd !== 16'h5AA5 || lat != 2) begin
      n_fail++; $display("FAIL clr_in_access_rd: got %h lat %0d, required 5aa5 lat 2", rd, lat);
    end
  endtask

  task automatic test_clear();
    int lat; logic [15:0] rd; int busy_cnt; int bad;
    do_access(1'b0, 1'b1, 8'h00, 16'hFFFF, lat, rd);
    do_access(1'b1, 1'b1, 8'hFF, 16'hFFFF, lat, rd);
    @(posedge clock); #1;
    bus.clr_start = 1'b1;
    @(posedge clock); #1;
    bus.clr_start = 1'b0;
    busy_cnt = 0;
    for (int g = 0; g < 400 && bus.clr_busy; g++) begin
      busy_cnt++;
      @(posedge clock); #1;
    end
    for (int i = 0; i < 256; i++) begin model_mem[i] = 16'h0; written[i] = 1'b1; end
    n_checks++;
    if (busy_cnt != 256) begin n_fail++; $display("FAIL clr_busy_len: got %0d, required 256", busy_cnt); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL clr_contents: got %0d words not zero, required 0", bad); end
    do_access(1'b0, 1'b0, 8'h00, 16'h0, lat, rd);
    n_checks++;
    if (rd !== 16'h0 || lat != 2) begin n_fail++; $display("FAIL clr_rd0: got %h lat %0d, required 0000 lat 2", rd, lat); end
    do_access(1'b1, 1'b0, 8'hFF, 16'h0, lat, rd);
    n_checks++;
    if (rd !== 16'h0 || lat != 2) begin n_fail++; $display("FAIL clr_rdff: got %h lat %0d, required 0000 lat 2", rd, lat); end
    exp_cpu_rd = 16'h0;
    exp_ldr_rd = 16'h0;
  endtask

  task automatic test_req_during_clear();
    int busy_cnt; int idle_c; int ack_c; bit seen; logic [15:0] rd;
    busy_cnt = 0; idle_c = -1; ack_c = -1; seen = 1'b0; rd = 16'h0;
    @(posedge clock); #1;
    bus.clr_start = 1'b1;
    @(posedge clock); #1;
    bus.clr_start = 1'b0;
    if (bus.clr_busy) busy_cnt++;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clock); #1;
      if (bus.clr_busy) busy_cnt++;
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(posedge clock); #1;
      if (bus.clr_busy) busy_cnt++;
      else if (idle_c < 0) idle_c = c;
      if (bus.cpu_ack) begin seen = 1'b1; ack_c = c; rd = bus.cpu_rdata; end
    end
    bus.cpu_req = 1'b0;
    n_checks++;
    if (!seen || idle_c < 0 || ack_c - idle_c != 2) begin
      n_fail++; $display("FAIL clr_wait_ack: ack cycle %0d idle cycle %0d, required ack 2 after idle", ack_c, idle_c);
    end
    n_checks++;
    if (busy_cnt != 256) begin n_fail++; $display("FAIL clr_wait_busy: got %0d, required 256", busy_cnt); end
    n_checks++;
    if (rd !== model_mem[8'h33]) begin n_fail++; $display("FAIL clr_wait_rd: got %h, required %h", rd, model_mem[8'h33]); end
    exp_cpu_rd = model_mem[8'h33];
  endtask

  task automatic test_reset_in_clear();
    int lat; logic [15:0] rd; bit found;
    do_access(1'b0, 1'b1, 8'h3F, 16'hA5A5, lat, rd); model_mem[8'h3F] = 16'hA5A5;
    do_access(1'b1, 1'b1, 8'h40, 16'h5A5A, lat, rd); model_mem[8'h40] = 16'h5A5A;
    do_access(1'b0, 1'b1, 8'h41, 16'hC3C3, lat, rd); model_mem[8'h41] = 16'hC3C3;
    @(posedge clock); #1;
    bus.clr_start = 1'b1;
    @(posedge clock); #1;
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 300 && !found; g++) begin
      if (bus.clr_busy && bus.mem_addr == 8'h40) found = 1'b1;
      else begin @(posedge clock); #1; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL clr_reach_40: sweep never reached addr 40"); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.clr_busy, bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ldr_ack} !== 5'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ldr_rdata} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_abort_outputs: ctrl %b addr %h wdata %h, required all 0",
               {bus.clr_busy, bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ldr_ack}, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    exp_cpu_rd = 16'h0;
    exp_ldr_rd = 16'h0;
    for (int i = 0; i < 8'h40; i++) model_mem[i] = 16'h0;
    n_checks++;
    if (ram[8'h41] !== model_mem[8'h41]) begin
      n_fail++; $display("FAIL abort_no_write: addr 41 got %h, required %h", ram[8'h41], model_mem[8'h41]);
    end
    n_checks++;
    if (ram[8'h3F] !== model_mem[8'h3F]) begin
      n_fail++; $display("FAIL abort_prior_cleared: addr 3f got %h, required %h", ram[8'h3F], model_mem[8'h3F]);
    end
    do_access(1'b0, 1'b0, 8'h41, 16'h0, lat, rd);
    n_checks++;
    if (rd !== 16'hC3C3 || lat != 2) begin
      n_fail++; $display("FAIL post_abort_rd: got %h lat %0d, required c3c3 lat 2", rd, lat);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_cpu_rd    = 16'h0;
    exp_ldr_rd    = 16'h0;
    reset_n       = 1'b0;
    bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h0; bus.cpu_wdata = 16'h0;
    bus.ldr_req   = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h0; bus.ldr_wdata = 16'h0;
    bus.clr_start = 1'b0;
    for (int i = 0; i < 256; i++) begin model_mem[i] = 16'h0; written[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_random();
    test_round_robin();
    test_clr_in_access();
    test_clear();
    test_req_during_clear();
    test_reset_in_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8: address width in bits.
REQ-002 Parameter DW, default 16: data width in bits; matches the 16-bit instruction/data word.
REQ-003 Parameter DEPTH, default 256: number of memory words swept by a clear (DEPTH <= 2**AW).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 cpu_req / cpu_we  input  1 / 1  processor access request, write when cpu_we=1; held until cpu_ack.
REQ-007 cpu_addr / cpu_wdata  input  AW / DW  processor address and write data; held stable while cpu_req=1.
REQ-008 cpu_ack / cpu_rdata  output  1 / DW  one-cycle completion pulse; read data valid while cpu_ack=1.
REQ-009 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: loader port, same widths and rules as the cpu port.
REQ-010 clr_start  input  1  one-cycle pulse requesting a zero-fill of the memory.
REQ-011 clr_busy  output  1  high while the clear sweep runs.
REQ-012 mem_en / mem_we  output  1 / 1  single-port synchronous RAM enable and write strobe.
REQ-013 mem_addr / mem_wdata  output  AW / DW  RAM address and write data.
REQ-014 mem_rdata  input  DW  RAM read data, valid the cycle after an enabled read.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ACCESS, DONE, CLEAR.
REQ-016 In IDLE, at each edge, the FSM SHALL apply this priority: clr_start -> CLEAR, else a granted requester -> ACCESS, else stay in IDLE.
REQ-017 Arbitration between cpu and ldr SHALL be round-robin: if both request, the port not granted last wins; after reset the cpu wins the first tie.
REQ-018 On grant, the FSM SHALL register the winner's addr, we, wdata and identity.
REQ-019 ACCESS SHALL last exactly one cycle with mem_en=1, mem_we=registered we, and registered addr/wdata driven.
REQ-020 DONE SHALL last one cycle: the granted ack=1, rdata=mem_rdata registered for reads (unchanged for writes), then the FSM returns to IDLE.
REQ-021 Latency SHALL be fixed: req sampled at edge N -> ack high in cycle N+2, for both reads and writes.
REQ-022 The non-granted requester SHALL see no ack and its request SHALL remain pending; there is no request queue.
REQ-023 Both acks SHALL never be high in the same cycle.
REQ-024 CLEAR SHALL write zero to addresses 0..DEPTH-1, one per cycle in ascending order (mem_en=mem_we=1, mem_wdata=0), with clr_busy=1 throughout; it returns to IDLE after address DEPTH-1.
REQ-025 clr_start SHALL be ignored outside IDLE; requests arriving during CLEAR wait and are not acknowledged until arbitrated in IDLE.
REQ-026 The clear address counter SHALL be AW+1 bits wide so DEPTH=2**AW terminates without wrap-around.
REQ-027 mem_en and mem_we SHALL be 0 in IDLE and DONE.
REQ-028 cpu_rdata and ldr_rdata SHALL be separate registers; each holds its last read value until that port's next read.
REQ-029 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, with cpu_ack=ldr_ack=0, clr_busy=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=ldr_rdata=0 and round-robin pointer=cpu.
REQ-031 Reset during ACCESS or CLEAR SHALL abort the operation: no ack is issued and no further RAM writes occur.

Verification
REQ-032 cpu write addr 0x05 data 0x1234, then cpu read 0x05 -> each ack 2 cycles after req; rdata=0x1234.
REQ-033 cpu and ldr request reads together for 3 consecutive transactions -> grants alternate cpu, ldr, cpu; acks never coincide.
REQ-034 Preload 0xFFFF at addr 0 and 0xFF; clr_start pulse -> clr_busy high for 256 cycles; read addr 0 and 0xFF -> 0x0000.
REQ-035 cpu_req asserted in the 10th CLEAR cycle -> no ack until clr_busy falls; ack 2 cycles after IDLE is re-entered.
REQ-036 reset_n pulled low in the CLEAR cycle writing addr 0x40 -> outputs at reset values at once; addr 0x41 is not written.
REQ-037 clr_start pulsed while in ACCESS -> ignored; access completes normally; clr_busy stays 0.
